npu_frame_writer: RTL and testbench

//  Upstream of the VGA display top: drains the systolic-array result stream into the frame RAM

---
 rtl/npu_vga_pkg.sv | 18 +
 rtl/npu_frame_writer_sat_clamp.sv | 28 ++
 rtl/npu_frame_writer.sv | 124 ++++++++++++
 tb/tb_npu_frame_writer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_vga_pkg.sv
// Shared types and geometry for the NPU-to-VGA frame path.
// Holds frame dimensions, pixel type and the frame writer state encoding.
package npu_vga_pkg;

    localparam int IMG_W      = 640;
    localparam int IMG_H      = 480;
    localparam int PIX_ADDR_W = 19;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } fw_state_t;

endpackage

// File: rtl/npu_frame_writer_sat_clamp.sv
// sat_clamp_u8: arithmetic right shift of a signed accumulator, then clamp to 0..255.
// Ports: acc (signed ACC_W in), pix (8-bit pixel out). Purely combinational.
module sat_clamp_u8
    import npu_vga_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output pixel_t                  pix
);

    localparam logic signed [ACC_W-1:0] MAX_PIX = ACC_W'(255);

    logic signed [ACC_W-1:0] s;

    always_comb begin
        s = acc >>> SHIFT;
        if (s[ACC_W-1]) begin
            pix = 8'd0;
        end else if (s > MAX_PIX) begin
            pix = 8'd255;
        end else begin
            pix = s[7:0];
        end
    end

endmodule

// File: rtl/npu_frame_writer.sv
// npu_frame_writer: drains the systolic-array result stream into the VGA frame RAM.
// Ports: clk/rst, start, in_valid/in_ready/in_acc/in_last beat stream,
// wr_en/wr_addr/wr_data RAM write port, busy, sticky frame_done and err_len.
module npu_frame_writer
    import npu_vga_pkg::*;
#(
    parameter int IMG_W     = npu_vga_pkg::IMG_W,
    parameter int IMG_H     = npu_vga_pkg::IMG_H,
    parameter int ADDR_W    = PIX_ADDR_W,
    parameter int BASE_ADDR = 0,
    parameter int ACC_W     = 20,
    parameter int SHIFT     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_acc,
    input  logic                    in_last,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output pixel_t                  wr_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err_len
);

    localparam int                N      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

    fw_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    pixel_t            wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    pixel_t            pix;
    logic              accept;
    logic              at_end;
    logic              final_beat;

    sat_clamp_u8 #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_clamp (
        .acc (in_acc),
        .pix (pix)
    );

    assign in_ready   = (state_q == RUN);
    assign accept     = in_valid & in_ready;
    assign at_end     = (cnt_q == LAST_K);
    assign final_beat = accept & (at_end | in_last);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        err_d     = err_q;
        wr_en_d   = accept;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            wr_addr_d = BASE + cnt_q;
            wr_data_d = pix;
        end
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                // Frame ends on whichever comes first: full count or in_last.
                // A mismatch between the two flags a length error.
                if (final_beat) begin
                    state_d = FLUSH;
                    err_d   = err_q | (at_end ^ in_last);
                end else if (accept) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            FLUSH: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q == RUN);
    assign frame_done = done_q;
    assign err_len    = err_q;

endmodule

// File: tb/tb_npu_frame_writer.sv
// Testbench for npu_frame_writer: two instances (SHIFT=0 and SHIFT=2)
// share one beat stream and are compared against a transaction-level model.
module tb_npu_frame_writer;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int N      = IMG_W * IMG_H;
    localparam int ADDR_W = 19;
    localparam int BASE   = 16;
    localparam int ACC_W  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic signed [ACC_W-1:0] in_acc = '0;

    logic              in_ready, wr_en, busy, frame_done, err_len;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              in_ready1, wr_en1, busy1, frame_done1, err_len1;
    logic [ADDR_W-1:0] wr_addr1;
    logic [7:0]        wr_data1;

    npu_frame_writer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE), .ACC_W(ACC_W), .SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_acc(in_acc), .in_last(in_last),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .err_len(err_len)
    );

    npu_frame_writer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE), .ACC_W(ACC_W), .SHIFT(2)
    ) dut_s2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready1), .in_acc(in_acc), .in_last(in_last),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .busy(busy1), .frame_done(frame_done1), .err_len(err_len1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int cyc;
        int addr;
        int data;
        int data1;
    } wr_t;

    wr_t exp_q[$];
    wr_t got_q[$];
    int  cyc;
    int  errors;
    int  checks;

    // Transaction-level model of the frame writer.
    bit m_run, m_flush, m_done, m_err;
    int m_k;

    function automatic int clamp_ref(input int a, input int sh);
        int d;
        int v;
        d = 1 << sh;
        if (a < 0) return 0;
        v = a / d;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_flush = 0; m_done = 0; m_err = 0; m_k = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    // One clock: drive at negedge, advance model at the edge,
    // capture any write #1 after the edge, return at next negedge.
    task automatic cycle(input bit s, input bit v, input int a, input bit l);
        wr_t w;
        bit  fin;
        start = s; in_valid = v; in_acc = ACC_W'(a); in_last = l;
        @(posedge clk);
        if (m_run) begin
            if (v) begin
                w.cyc = cyc; w.addr = BASE + m_k;
                w.data = clamp_ref(a, 0); w.data1 = clamp_ref(a, 2);
                exp_q.push_back(w);
                fin = (m_k == N - 1) || l;
                if (fin) begin
                    m_run = 0; m_flush = 1;
                    if ((m_k == N - 1) != l) m_err = 1;
                end else begin
                    m_k++;
                end
            end
        end else if (m_flush) begin
            m_flush = 0; m_done = 1;
        end else if (s) begin
            m_run = 1; m_k = 0; m_done = 0; m_err = 0;
        end
        #1;
        if (wr_en) begin
            w.cyc = cyc; w.addr = int'(wr_addr);
            w.data = int'(wr_data); w.data1 = int'(wr_data1);
            got_q.push_back(w);
        end
        cyc++;
        @(negedge clk);
        start = 0; in_valid = 0; in_last = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        #2;
        checks++;
        if ({in_ready, wr_en, busy, frame_done, err_len} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {in_ready, wr_en, busy, frame_done, err_len});
        end
        checks++;
        if (wr_addr !== '0 || wr_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_wr got addr=%0d data=%0d exp 0/0", wr_addr, wr_data);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_basic_frame();
        model_reset();
        cycle(1, 0, 0, 0);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_ready got=%b/%b exp=1/1", in_ready, busy);
        end
        for (int i = 0; i < N; i++) cycle(0, 1, i, i == N - 1);
        checks++;
        if (in_ready !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL t1_flush got ready=%b done=%b exp 0/0", in_ready, frame_done);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (frame_done !== 1'b1 || err_len !== 1'b0) begin
            errors++;
            $display("FAIL t1_done got done=%b err=%b exp 1/0", frame_done, err_len);
        end
        checks++;
        if (got_q.size() != N) begin
            errors++;
            $display("FAIL t1_count got=%0d exp=%0d", got_q.size(), N);
        end
        foreach (got_q[i]) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i]
                || got_q[i].addr != BASE + i || got_q[i].data != i) begin
                errors++;
                $display("FAIL t1_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d",
                         i, got_q[i].addr, got_q[i].data, BASE + i, i);
            end
        end
    endtask

    task automatic test_clamp();
        int vals[8];
        vals = '{-5, 255, 256, 524287, 1023, -4, 400, 0};
        model_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < N; i++) cycle(0, 1, vals[i], i == N - 1);
        cycle(0, 0, 0, 0);
        checks++;
        if (got_q.size() != N) begin
            errors++;
            $display("FAIL t2_count got=%0d exp=%0d", got_q.size(), N);
        end
        foreach (got_q[i]) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL t2_clamp[%0d] got d0=%0d d2=%0d exp d0=%0d d2=%0d", i,
                         got_q[i].data, got_q[i].data1,
                         clamp_ref(vals[i], 0), clamp_ref(vals[i], 2));
            end
        end
        checks++;
        if (got_q.size() == N
            && (got_q[3].data != 255 || got_q[4].data1 != 255
                || got_q[5].data1 != 0 || got_q[6].data1 != 100)) begin
            errors++;
            $display("FAIL t2_points got %0d %0d %0d %0d exp 255 255 0 100",
                     got_q[3].data, got_q[4].data1, got_q[5].data1, got_q[6].data1);
        end
    endtask

    task automatic test_random_valid();
        int  n;
        bit  v;
        model_reset();
        cycle(1, 0, 0, 0);
        n = 0;
        while (m_run && n < 100) begin
            v = 1'($urandom_range(0, 1));
            cycle(0, v, int'($urandom_range(0, 4000)) - 2000, v && m_k == N - 1);
            n++;
        end
        checks++;
        if (m_run) begin
            errors++;
            $display("FAIL t3_timeout got beats=%0d exp=%0d", m_k, N);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (got_q.size() != N || exp_q.size() != N) begin
            errors++;
            $display("FAIL t3_count got=%0d exp=%0d", got_q.size(), N);
        end
        foreach (got_q[i]) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL t3_write[%0d] got cyc=%0d addr=%0d data=%0d", i,
                         got_q[i].cyc, got_q[i].addr, got_q[i].data);
            end
        end
        checks++;
        if (frame_done !== 1'b1 || err_len !== 1'b0) begin
            errors++;
            $display("FAIL t3_done got done=%b err=%b exp 1/0", frame_done, err_len);
        end
    endtask

    task automatic test_truncated();
        model_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, i + 40, i == 2);
        cycle(0, 1, 77, 0);
        checks++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL t4_count got=%0d exp=3", got_q.size());
        end
        foreach (got_q[i]) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i] || got_q[i].addr != BASE + i) begin
                errors++;
                $display("FAIL t4_write[%0d] got addr=%0d exp=%0d", i, got_q[i].addr, BASE + i);
            end
        end
        checks++;
        if (frame_done !== 1'b1 || err_len !== 1'b1) begin
            errors++;
            $display("FAIL t4_flags got done=%b err=%b exp 1/1", frame_done, err_len);
        end
        cycle(1, 0, 0, 0);
        checks++;
        if (frame_done !== 1'b0 || err_len !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t4_clear got done=%b err=%b busy=%b exp 0/0/1",
                     frame_done, err_len, busy);
        end
        for (int i = 0; i < N; i++) cycle(0, 1, i, i == N - 1);
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_reset_midframe();
        model_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, i + 10, 0);
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL t5_pre got wr_en=%b exp=1", wr_en);
        end
        rst = 1;
        #1;
        checks++;
        if ({wr_en, in_ready, busy, frame_done} !== 4'b0) begin
            errors++;
            $display("FAIL t5_rst got=%b exp=0000", {wr_en, in_ready, busy, frame_done});
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < N; i++) cycle(i == 3, 1, i * 30, i == N - 1);
        cycle(0, 0, 0, 0);
        checks++;
        if (got_q.size() != N) begin
            errors++;
            $display("FAIL t5_count got=%0d exp=%0d", got_q.size(), N);
        end
        foreach (got_q[i]) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i] || got_q[i].addr != BASE + i) begin
                errors++;
                $display("FAIL t5_write[%0d] got addr=%0d exp=%0d", i, got_q[i].addr, BASE + i);
            end
        end
        checks++;
        if (frame_done !== 1'b1 || err_len !== 1'b0) begin
            errors++;
            $display("FAIL t5_done got done=%b err=%b exp 1/0", frame_done, err_len);
        end
    endtask

    task automatic test_no_last();
        model_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < N; i++) cycle(0, 1, 200 + i, 0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL t6_ready got=%b exp=0", in_ready);
        end
        cycle(0, 1, 5, 0);
        cycle(0, 1, 6, 1);
        checks++;
        if (got_q.size() != N || exp_q.size() != N) begin
            errors++;
            $display("FAIL t6_count got=%0d exp=%0d", got_q.size(), N);
        end
        foreach (got_q[i]) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL t6_write[%0d] got addr=%0d data=%0d", i,
                         got_q[i].addr, got_q[i].data);
            end
        end
        checks++;
        if (got_q.size() == 0 || got_q[got_q.size() - 1].addr != BASE + N - 1) begin
            errors++;
            $display("FAIL t6_last_addr got=%0d exp=%0d",
                     got_q.size() ? got_q[got_q.size() - 1].addr : -1, BASE + N - 1);
        end
        checks++;
        if (frame_done !== 1'b1 || err_len !== 1'b1) begin
            errors++;
            $display("FAIL t6_flags got done=%b err=%b exp 1/1", frame_done, err_len);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_clamp();
        test_random_valid();
        test_truncated();
        test_reset_midframe();
        test_no_last();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
